// File: rtl/nbbpu_pkg.sv
// Shared definitions for the NBBPU memory responder: word width, the
// memory-mapped output register address, and the instruction-step FSM
// encoding with its sequencing function.
package nbbpu_pkg;

    localparam int WORD_WIDTH = 16;

    // Full 16-bit address of the memory-mapped output register.
    localparam logic [WORD_WIDTH-1:0] IO_ADDR_DEFAULT = 16'hFFFF;

    // One instruction walks FETCH..STEP; IDLE is the parked state.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_DATA   = 3'd3,
        ST_LOAD   = 3'd4,
        ST_STEP   = 3'd5
    } state_e;

    // Fixed five-cycle walk; run only matters when leaving IDLE or STEP,
    // so dropping run mid-instruction never aborts it.
    function automatic state_e next_state(input state_e cur, input logic run);
        state_e nxt;
        case (cur)
            ST_IDLE:   nxt = run ? ST_FETCH : ST_IDLE;
            ST_FETCH:  nxt = ST_DECODE;
            ST_DECODE: nxt = ST_DATA;
            ST_DATA:   nxt = ST_LOAD;
            ST_LOAD:   nxt = ST_STEP;
            ST_STEP:   nxt = run ? ST_FETCH : ST_IDLE;
            default:   nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/nbbpu_io_port.sv
// Memory-mapped output register: full-width address match, the io_out
// register written by a DATA-cycle store, and the load read-back mux that
// returns io_out instead of RAM data when the core reads IO_ADDR.
module nbbpu_io_port
    import nbbpu_pkg::*;
#(
    parameter logic [WORD_WIDTH-1:0] IO_ADDR = IO_ADDR_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,          // asynchronous, active-low
    input  logic [WORD_WIDTH-1:0] address,        // untruncated core data address
    input  logic [WORD_WIDTH-1:0] write_data,
    input  logic                  store_cycle,    // DATA state with write_enable=1
    input  logic [WORD_WIDTH-1:0] mem_read_data,
    output logic                  io_match,
    output logic [WORD_WIDTH-1:0] io_out,
    output logic [WORD_WIDTH-1:0] load_data
);

    logic [WORD_WIDTH-1:0] io_out_d;
    logic [WORD_WIDTH-1:0] io_out_q;

    // Match on all 16 bits so RAM aliases of IO_ADDR never hit the register.
    always_comb begin
        io_match = (address == IO_ADDR);
    end

    // Capture store data only on a store that targets the register.
    always_comb begin
        io_out_d = io_out_q;
        if (store_cycle && io_match) begin
            io_out_d = write_data;
        end
    end

    // Output register, cleared by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_out_q <= '0;
        end else begin
            io_out_q <= io_out_d;
        end
    end

    // Loads from IO_ADDR see the register; everything else sees RAM.
    always_comb begin
        load_data = io_match ? io_out_q : mem_read_data;
    end

    assign io_out = io_out_q;

endmodule

// File: rtl/nbbpu_memory_responder.sv
// Memory-side responder for the NBBPU core. Serves instruction fetch and
// data load/store from one single-port synchronous RAM using a fixed
// five-cycle step (FETCH, DECODE, DATA, LOAD, STEP) and releases the core
// with a one-cycle cpu_enable pulse in STEP.
//
// RAM read data arrives the cycle after the address is presented, so the
// instruction is captured in DECODE (address given in FETCH) and load data
// in LOAD (address given in DATA). mem_write_enable and cpu_enable are
// decoded from the state register alone plus core inputs that are stable
// from DATA onward; an asynchronous reset forces IDLE and drops both at once.
module nbbpu_memory_responder
    import nbbpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 12,
    parameter logic [WORD_WIDTH-1:0] IO_ADDR    = IO_ADDR_DEFAULT,
    // Reset value of the instruction counter; 0 in normal use, a nonzero
    // preload exists so the wrap can be exercised without 64K instructions.
    parameter logic [WORD_WIDTH-1:0] COUNT_INIT = 16'h0000
) (
    input  logic                  clock,
    input  logic                  reset,            // asynchronous, active-low
    input  logic                  run,
    input  logic [WORD_WIDTH-1:0] PC,
    input  logic [WORD_WIDTH-1:0] address,
    input  logic [WORD_WIDTH-1:0] write_data,
    input  logic                  write_enable,
    output logic [WORD_WIDTH-1:0] instruction,
    output logic [WORD_WIDTH-1:0] read_data,
    output logic                  cpu_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [WORD_WIDTH-1:0] mem_write_data,
    output logic                  mem_write_enable,
    input  logic [WORD_WIDTH-1:0] mem_read_data,
    output logic [WORD_WIDTH-1:0] io_out,
    output logic [WORD_WIDTH-1:0] instruction_count
);

    state_e                state_q;
    state_e                state_d;
    logic [WORD_WIDTH-1:0] instruction_q;
    logic [WORD_WIDTH-1:0] instruction_d;
    logic [WORD_WIDTH-1:0] read_data_q;
    logic [WORD_WIDTH-1:0] read_data_d;
    logic [WORD_WIDTH-1:0] count_q;
    logic [WORD_WIDTH-1:0] count_d;

    logic                  io_store;
    logic                  io_match;
    logic [WORD_WIDTH-1:0] io_load_data;

    // RAM only sees the low PC bits; the upper bits are intentionally dropped.
    logic                  unused_pc_hi;
    assign unused_pc_hi = ^PC[WORD_WIDTH-1:ADDR_WIDTH];

    // A store is in flight during DATA whenever the core asks for a write.
    always_comb begin
        io_store = (state_q == ST_DATA) && write_enable;
    end

    nbbpu_io_port #(
        .IO_ADDR       (IO_ADDR)
    ) u_io_port (
        .clock         (clock),
        .reset         (reset),
        .address       (address),
        .write_data    (write_data),
        .store_cycle   (io_store),
        .mem_read_data (mem_read_data),
        .io_match      (io_match),
        .io_out        (io_out),
        .load_data     (io_load_data)
    );

    // Next-state and datapath next values; registers hold outside their slot.
    always_comb begin
        state_d       = next_state(state_q, run);
        instruction_d = instruction_q;
        read_data_d   = read_data_q;
        count_d       = count_q;
        case (state_q)
            ST_DECODE: instruction_d = mem_read_data;
            ST_LOAD: begin
                if (!write_enable) begin
                    read_data_d = io_load_data;
                end
            end
            ST_STEP:   count_d = count_q + 16'd1;   // wraps naturally
            default: ;
        endcase
    end

    // RAM-side bus decoded from the current state: PC in FETCH, the data
    // address in DATA, and a write strobe only for non-IO stores.
    always_comb begin
        mem_address      = '0;
        mem_write_data   = '0;
        mem_write_enable = 1'b0;
        case (state_q)
            ST_FETCH: mem_address = PC[ADDR_WIDTH-1:0];
            ST_DATA: begin
                mem_address      = address[ADDR_WIDTH-1:0];
                mem_write_data   = write_data;
                mem_write_enable = write_enable && !io_match;
            end
            default: ;
        endcase
    end

    // Core release pulse: exactly the STEP cycle, never alongside a write.
    always_comb begin
        cpu_enable = (state_q == ST_STEP);
    end

    // FSM state and datapath registers; reset aborts any instruction.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            instruction_q <= '0;
            read_data_q   <= '0;
            count_q       <= COUNT_INIT;
        end else begin
            state_q       <= state_d;
            instruction_q <= instruction_d;
            read_data_q   <= read_data_d;
            count_q       <= count_d;
        end
    end

    assign instruction       = instruction_q;
    assign read_data         = read_data_q;
    assign instruction_count = count_q;

endmodule

// File: tb/tb_nbbpu_memory_responder.sv
// Directed bench for nbbpu_memory_responder: a bench-owned synchronous RAM,
// one linear initial block of steps, and immediate-assertion checks against
// hand-computed values. A second instance with a counter preload of 16'hFFFF
// covers the counter wrap.
module tb_nbbpu_memory_responder;

    logic        clock;
    logic        reset;
    logic        run;
    logic [15:0] PC;
    logic [15:0] address;
    logic [15:0] write_data;
    logic        write_enable;
    logic [15:0] instruction;
    logic [15:0] read_data;
    logic        cpu_enable;
    logic [11:0] mem_address;
    logic [15:0] mem_write_data;
    logic        mem_write_enable;
    logic [15:0] mem_read_data;
    logic [15:0] io_out;
    logic [15:0] instruction_count;

    // wrap-test instance
    logic        reset_w;
    logic        run_w;
    logic        cpu_enable_w;
    logic [15:0] count_w;
    logic [15:0] unused_w_instruction;
    logic [15:0] unused_w_read_data;
    logic [11:0] unused_w_mem_address;
    logic [15:0] unused_w_mem_write_data;
    logic        unused_w_mem_write_enable;
    logic [15:0] unused_w_io_out;

    // bench RAM and its preload port
    logic [15:0] ram [0:4095];
    logic        tb_we;
    logic [11:0] tb_wa;
    logic [15:0] tb_wd;

    int total = 0;
    int bad   = 0;
    int pulse_cnt = 0;

    nbbpu_memory_responder dut (
        .clock             (clock),
        .reset             (reset),
        .run               (run),
        .PC                (PC),
        .address           (address),
        .write_data        (write_data),
        .write_enable      (write_enable),
        .instruction       (instruction),
        .read_data         (read_data),
        .cpu_enable        (cpu_enable),
        .mem_address       (mem_address),
        .mem_write_data    (mem_write_data),
        .mem_write_enable  (mem_write_enable),
        .mem_read_data     (mem_read_data),
        .io_out            (io_out),
        .instruction_count (instruction_count)
    );

    nbbpu_memory_responder #(
        .COUNT_INIT (16'hFFFF)
    ) dut_w (
        .clock             (clock),
        .reset             (reset_w),
        .run               (run_w),
        .PC                (PC),
        .address           (address),
        .write_data        (write_data),
        .write_enable      (write_enable),
        .instruction       (unused_w_instruction),
        .read_data         (unused_w_read_data),
        .cpu_enable        (cpu_enable_w),
        .mem_address       (unused_w_mem_address),
        .mem_write_data    (unused_w_mem_write_data),
        .mem_write_enable  (unused_w_mem_write_enable),
        .mem_read_data     (16'h0000),
        .io_out            (unused_w_io_out),
        .instruction_count (count_w)
    );

    // clock / reset block
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // synchronous RAM: read data valid the cycle after the address
    always @(posedge clock) begin
        if (tb_we) begin
            ram[tb_wa] <= tb_wd;
        end else if (mem_write_enable) begin
            ram[mem_address] <= mem_write_data;
        end
        mem_read_data <= ram[mem_address];
    end

    // count every core release pulse seen at a clock edge
    always @(posedge clock) begin
        if (cpu_enable === 1'b1) begin
            pulse_cnt <= pulse_cnt + 1;
        end
    end

    // one clock, then settle away from the edge
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic ram_write(input logic [11:0] a, input logic [15:0] d);
        tb_we = 1'b1;
        tb_wa = a;
        tb_wd = d;
        step();
        tb_we = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset        = 1'b0;
        reset_w      = 1'b0;
        run          = 1'b1;
        run_w        = 1'b0;
        PC           = 16'h0000;
        address      = 16'h0010;
        write_data   = 16'hBEEF;
        write_enable = 1'b1;
        tb_we        = 1'b0;
        tb_wa        = '0;
        tb_wd        = '0;

        // preload RAM while the responder is held in reset
        ram_write(12'h000, 16'h1234);
        ram_write(12'h001, 16'h0777);
        ram_write(12'h002, 16'h2222);
        ram_write(12'h003, 16'h0F0F);
        ram_write(12'h004, 16'h4444);
        ram_write(12'h010, 16'h0000);
        ram_write(12'h020, 16'h00AA);
        ram_write(12'h030, 16'h0000);
        ram_write(12'hFFF, 16'h1111);

        // reset held with run=1 and write_enable=1: everything quiet
        step();
        chk("rst_instruction", instruction, 16'h0000);
        chk("rst_read_data", read_data, 16'h0000);
        chk("rst_io_out", io_out, 16'h0000);
        chk("rst_count", instruction_count, 16'h0000);
        chk("rst_cpu_enable", {15'd0, cpu_enable}, 16'h0000);
        chk("rst_mem_we", {15'd0, mem_write_enable}, 16'h0000);
        chk("rst_mem_address", {4'd0, mem_address}, 16'h0000);
        chk("rst_mem_wdata", mem_write_data, 16'h0000);
        chk("rst_pulses", pulse_cnt[15:0], 16'h0000);

        // instruction 1: fetch RAM[0], store BEEF to 0x0010
        reset = 1'b1;
        step();                                                     // cycle 0 FETCH
        chk("i1_c0_mem_address", {4'd0, mem_address}, 16'h0000);
        chk("i1_c0_mem_we", {15'd0, mem_write_enable}, 16'h0000);
        step();                                                     // cycle 1 DECODE
        chk("i1_c1_instruction", instruction, 16'h0000);
        chk("i1_c1_cpu_enable", {15'd0, cpu_enable}, 16'h0000);
        step();                                                     // cycle 2 DATA
        chk("i1_c2_instruction", instruction, 16'h1234);
        chk("i1_c2_mem_we", {15'd0, mem_write_enable}, 16'h0001);
        chk("i1_c2_mem_address", {4'd0, mem_address}, 16'h0010);
        chk("i1_c2_mem_wdata", mem_write_data, 16'hBEEF);
        chk("i1_c2_cpu_enable", {15'd0, cpu_enable}, 16'h0000);
        step();                                                     // cycle 3 LOAD
        chk("i1_c3_mem_we", {15'd0, mem_write_enable}, 16'h0000);
        chk("i1_c3_cpu_enable", {15'd0, cpu_enable}, 16'h0000);
        PC = 16'h0001;
        step();                                                     // cycle 4 STEP
        chk("i1_c4_cpu_enable", {15'd0, cpu_enable}, 16'h0001);
        chk("i1_c4_mem_we", {15'd0, mem_write_enable}, 16'h0000);
        chk("i1_c4_read_data", read_data, 16'h0000);
        chk("i1_c4_count", instruction_count, 16'h0000);
        step();                                                     // cycle 5 FETCH
        chk("i1_c5_cpu_enable", {15'd0, cpu_enable}, 16'h0000);
        chk("i1_c5_count", instruction_count, 16'h0001);
        chk("i1_ram_010", ram[12'h010], 16'hBEEF);

        // instruction 2: load through an alias of 0x020
        chk("i2_fetch_mem_address", {4'd0, mem_address}, 16'h0001);
        address      = 16'h1020;
        write_enable = 1'b0;
        step();                                                     // DECODE
        step();                                                     // DATA
        chk("i2_instruction", instruction, 16'h0777);
        chk("i2_mem_address", {4'd0, mem_address}, 16'h0020);
        chk("i2_mem_we", {15'd0, mem_write_enable}, 16'h0000);
        step();                                                     // LOAD
        PC = 16'h0002;
        step();                                                     // STEP
        chk("i2_read_data", read_data, 16'h00AA);
        chk("i2_cpu_enable", {15'd0, cpu_enable}, 16'h0001);
        step();                                                     // FETCH
        chk("i2_count", instruction_count, 16'h0002);

        // instruction 3: store 5A5A to the IO register
        address      = 16'hFFFF;
        write_data   = 16'h5A5A;
        write_enable = 1'b1;
        step();                                                     // DECODE
        step();                                                     // DATA
        chk("i3_instruction", instruction, 16'h2222);
        chk("i3_mem_we", {15'd0, mem_write_enable}, 16'h0000);
        chk("i3_io_before", io_out, 16'h0000);
        step();                                                     // LOAD
        chk("i3_io_out", io_out, 16'h5A5A);
        chk("i3_mem_we_load", {15'd0, mem_write_enable}, 16'h0000);
        PC = 16'h0003;
        step();                                                     // STEP
        chk("i3_read_data_held", read_data, 16'h00AA);
        step();                                                     // FETCH
        chk("i3_ram_fff", ram[12'hFFF], 16'h1111);
        chk("i3_count", instruction_count, 16'h0003);

        // instruction 4: load back from IO, run dropped during DECODE
        write_enable = 1'b0;
        step();                                                     // DECODE
        run = 1'b0;
        step();                                                     // DATA
        step();                                                     // LOAD
        PC = 16'h0005;
        step();                                                     // STEP
        chk("i4_cpu_enable", {15'd0, cpu_enable}, 16'h0001);
        chk("i4_read_data", read_data, 16'h5A5A);
        step();                                                     // IDLE
        chk("i4_idle_cpu_enable", {15'd0, cpu_enable}, 16'h0000);
        chk("i4_count", instruction_count, 16'h0004);
        for (int i = 0; i < 4; i++) begin
            step();
        end
        chk("i4_idle_mem_address", {4'd0, mem_address}, 16'h0000);
        chk("i4_idle_count", instruction_count, 16'h0004);
        chk("i4_idle_pulses", pulse_cnt[15:0], 16'h0004);
        chk("i4_idle_instruction", instruction, 16'h0F0F);
        chk("i4_idle_read_data", read_data, 16'h5A5A);

        // instruction 5: reset lands during a DATA-cycle store
        PC           = 16'h0004;
        address      = 16'h0030;
        write_data   = 16'hCAFE;
        write_enable = 1'b1;
        run          = 1'b1;
        step();                                                     // FETCH
        chk("i5_fetch_mem_address", {4'd0, mem_address}, 16'h0004);
        step();                                                     // DECODE
        step();                                                     // DATA
        chk("i5_mem_we_before", {15'd0, mem_write_enable}, 16'h0001);
        #1;
        reset = 1'b0;
        #1;
        chk("i5_mem_we_reset", {15'd0, mem_write_enable}, 16'h0000);
        chk("i5_cpu_enable_reset", {15'd0, cpu_enable}, 16'h0000);
        chk("i5_count_reset", instruction_count, 16'h0000);
        chk("i5_instruction_reset", instruction, 16'h0000);
        chk("i5_read_data_reset", read_data, 16'h0000);
        chk("i5_io_out_reset", io_out, 16'h0000);
        step();
        step();
        chk("i5_ram_030", ram[12'h030], 16'h0000);
        chk("i5_pulses", pulse_cnt[15:0], 16'h0004);

        // counter wrap on the preloaded instance
        chk("w_count_preload", count_w, 16'hFFFF);
        reset_w = 1'b1;
        run_w   = 1'b1;
        step();                                                     // FETCH
        step();                                                     // DECODE
        step();                                                     // DATA
        step();                                                     // LOAD
        chk("w_load_cpu_enable", {15'd0, cpu_enable_w}, 16'h0000);
        run_w = 1'b0;
        step();                                                     // STEP
        chk("w_step_cpu_enable", {15'd0, cpu_enable_w}, 16'h0001);
        chk("w_step_count", count_w, 16'hFFFF);
        step();                                                     // IDLE
        chk("w_wrapped_count", count_w, 16'h0000);
        chk("w_idle_cpu_enable", {15'd0, cpu_enable_w}, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nbbpu_memory_responder.md
Name: nbbpu_memory_responder

Overview:
- Memory-side responder for the NBBPU core; the other end of the core's instruction/data bus.
- Serves the core's instruction fetch (PC -> instruction) and data access (address/write_data/write_enable -> read_data) from one single-port synchronous RAM.
- Sequences each instruction as a fixed 5-cycle step and releases the core with a one-cycle cpu_enable pulse.
- Decodes one memory-mapped output register (io_out) and keeps an instruction counter.

Parameters:
- ADDR_WIDTH, 12, RAM word-address width (4096 x 16-bit words).
- IO_ADDR, 16'hFFFF, full 16-bit address of the memory-mapped output register.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- run  input  1  1 = keep stepping; 0 = finish the current instruction, then park in IDLE.
- PC  input  16  core program counter.
- address  input  16  core data address.
- write_data  input  16  core store data.
- write_enable  input  1  core store request; 0 = load.
- instruction  output  16  registered instruction word to the core.
- read_data  output  16  registered load data to the core.
- cpu_enable  output  1  one-cycle pulse; the core's registers and PC update only when this is 1.
- mem_address  output  ADDR_WIDTH  RAM word address.
- mem_write_data  output  16  RAM write data.
- mem_write_enable  output  1  RAM write strobe.
- mem_read_data  input  16  RAM read data; valid in the cycle after mem_address is presented.
- io_out  output  16  memory-mapped output register.
- instruction_count  output  16  count of completed instructions; wraps.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE.
  - instruction, read_data, io_out, instruction_count = 16'h0000.
  - cpu_enable = 0 and mem_write_enable = 0, both immediately.
  - mem_address and mem_write_data = 0.
- State machine: IDLE -> FETCH -> DECODE -> DATA -> LOAD -> STEP -> (FETCH if run, else IDLE). IDLE -> FETCH when run=1.
- FETCH: mem_address = PC[ADDR_WIDTH-1:0], mem_write_enable = 0.
- DECODE: instruction <= mem_read_data at the end of the cycle. Core outputs are valid from DATA onward.
- DATA:
  - mem_address = address[ADDR_WIDTH-1:0] and mem_write_data = write_data.
  - If write_enable=1 and address != IO_ADDR: mem_write_enable = 1 for this cycle only.
  - If write_enable=1 and address == IO_ADDR: io_out <= write_data and mem_write_enable stays 0.
- LOAD: if write_enable=0, read_data <= (address == IO_ADDR) ? io_out : mem_read_data. On a store, read_data holds its value.
- STEP: cpu_enable = 1 for exactly this cycle; instruction_count <= instruction_count + 1, wrapping 16'hFFFF -> 16'h0000.
- Latency: 5 cycles per instruction. The instruction is visible 2 cycles after FETCH; load data 4 cycles after FETCH.
- mem_write_enable and cpu_enable are Moore outputs (decoded from state plus registered/stable inputs) and are never asserted in the same cycle.
- Address aliasing: RAM addresses are truncated to the low ADDR_WIDTH bits. IO_ADDR is matched on all 16 bits before truncation, so IO_ADDR never reaches RAM.
- run is sampled only in STEP and IDLE. Deasserting run mid-instruction does not abort the instruction.
- Reset mid-instruction aborts it: any DATA-cycle write is dropped combinationally and no cpu_enable pulse is issued.
- instruction and read_data hold their values in IDLE.

Decomposition:
- Shared package nbbpu_pkg holds:
  - state encoding constants (IDLE, FETCH, DECODE, DATA, LOAD, STEP; 3 bits);
  - IO_ADDR default;
  - WORD_WIDTH = 16.
- One sub-module, nbbpu_io_port: the IO_ADDR match, the io_out register, and the read-back mux.
- The FSM, datapath registers and counter stay in the top module.

Test Plan:
- Reset: hold reset=0 with run=1 and write_enable=1 -> all outputs 0, mem_write_enable=0, no cpu_enable. Release reset -> FETCH on the first edge with run=1.
- Fetch timing: RAM[0]=16'h1234, PC=0, run=1 -> mem_address=0 in cycle 0; instruction=16'h1234 from cycle 2; cpu_enable=1 only in cycle 4; next FETCH in cycle 5; instruction_count=1.
- Store: address=16'h0010, write_data=16'hBEEF, write_enable=1 -> mem_write_enable=1 exactly in cycle 2 with mem_address=12'h010; read_data unchanged; RAM[0x010]=16'hBEEF afterwards.
- Load and alias:
  - RAM[0x020]=16'h00AA, address=16'h1020, write_enable=0 -> mem_address=12'h020 in cycle 2; read_data=16'h00AA from cycle 4.
- IO:
  - Store 16'h5A5A to 16'hFFFF -> io_out=16'h5A5A and mem_write_enable never 1.
  - A following load from 16'hFFFF -> read_data=16'h5A5A.
- Control boundaries:
  - run=0 asserted in DECODE -> instruction completes (cpu_enable pulse), then IDLE with no further FETCH.
  - reset=0 during a DATA store -> mem_write_enable drops in the same cycle; instruction_count=0.
  - Preload count 16'hFFFF -> wraps to 16'h0000 after one STEP.
